// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer in front of the PWM core: steps pwm_value toward a commanded
// target, applying every output change only on the core's end-of-period pulse.
module pwm_fade_ctrl #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_target,
    input  logic [DATA_W-1:0] cmd_step,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic [DATA_W-1:0] cmd_range,
    input  logic              cmd_en,
    input  logic              cmd_abort,
    input  logic              pwm_period,
    output logic [DATA_W-1:0] pwm_value,
    output logic [DATA_W-1:0] pwm_range,
    output logic              pwm_en,
    output logic              busy,
    output logic              done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RAMP = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] tgt_q, tgt_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DATA_W-1:0] range_sh_q, range_sh_d;
    logic              en_sh_q, en_sh_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [DATA_W-1:0] range_q, range_d;
    logic              en_q, en_d;
    logic              done_q, done_d;

    // Distance to target at one extra bit so the comparison against step never wraps.
    logic [DATA_W:0]   diff;
    logic              going_up;

    assign going_up = (tgt_q >= value_q);
    assign diff     = going_up ? ({1'b0, tgt_q} - {1'b0, value_q})
                               : ({1'b0, value_q} - {1'b0, tgt_q});

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves
        // a variable unassigned and no latch is inferred.
        state_d    = state_q;
        tgt_d      = tgt_q;
        step_d     = step_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        range_sh_d = range_sh_q;
        en_sh_d    = en_sh_q;
        first_d    = first_q;
        value_d    = value_q;
        range_d    = range_q;
        en_d       = en_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    tgt_d      = cmd_target;
                    step_d     = cmd_step;
                    div_d      = cmd_div;
                    range_sh_d = cmd_range;
                    en_sh_d    = cmd_en;
                    div_cnt_d  = cmd_div;
                    first_d    = 1'b1;
                    state_d    = RAMP;
                end
            end
            RAMP: begin
                if (cmd_abort) begin
                    first_d = 1'b0;
                    state_d = IDLE;
                end else if (pwm_period) begin
                    if (first_q) begin
                        range_d = range_sh_q;
                        en_d    = en_sh_q;
                        first_d = 1'b0;
                    end
                    if (div_cnt_q != '0) begin
                        div_cnt_d = div_cnt_q - 1'b1;
                    end else begin
                        div_cnt_d = div_q;
                        if (step_q == '0 || diff <= {1'b0, step_q}) begin
                            value_d = tgt_q;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (going_up) begin
                            value_d = value_q + step_q;
                        end else begin
                            value_d = value_q - step_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            step_q     <= '0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            range_sh_q <= '1;
            en_sh_q    <= 1'b0;
            first_q    <= 1'b0;
            value_q    <= '0;
            range_q    <= '1;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            step_q     <= step_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            range_sh_q <= range_sh_d;
            en_sh_q    <= en_sh_d;
            first_q    <= first_d;
            value_q    <= value_d;
            range_q    <= range_d;
            en_q       <= en_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RAMP);
    assign pwm_value = value_q;
    assign pwm_range = range_q;
    assign pwm_en    = en_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: stimulus queues the expected outputs for
// every period pulse, a monitor compares them on the following falling edge.
module tb_pwm_fade_ctrl;

    typedef struct {
        logic [7:0] value;
        logic [7:0] range;
        logic       en;
        logic       done;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;
    logic [3:0] cmd_div;
    logic [7:0] cmd_range;
    logic       cmd_en;
    logic       cmd_abort;
    logic       pwm_period;
    logic [7:0] pwm_value;
    logic [7:0] pwm_range;
    logic       pwm_en;
    logic       busy;
    logic       done;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];

    pwm_fade_ctrl #(.DATA_W(8), .DIV_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_div    (cmd_div),
        .cmd_range  (cmd_range),
        .cmd_en     (cmd_en),
        .cmd_abort  (cmd_abort),
        .pwm_period (pwm_period),
        .pwm_value  (pwm_value),
        .pwm_range  (pwm_range),
        .pwm_en     (pwm_en),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [7:0] v, input logic [7:0] r, input logic e,
                                input logic d, input logic b);
        exp_t x;
        x.value = v; x.range = r; x.en = e; x.done = d; x.busy = b;
        return x;
    endfunction

    // Monitor: each period pulse seen at a rising edge is checked half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (pwm_period && !reset) begin
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("mon_value", 32'(pwm_value), 32'(e.value));
                    check("mon_range", 32'(pwm_range), 32'(e.range));
                    check("mon_en",    32'(pwm_en),    32'(e.en));
                    check("mon_done",  32'(done),      32'(e.done));
                    check("mon_busy",  32'(busy),      32'(e.busy));
                end
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse(input exp_t e);
        repeat (15) @(negedge clk);
        pwm_period = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        pwm_period = 1'b0;
    endtask

    task automatic set_cmd(input logic [7:0] t, input logic [7:0] s, input logic [3:0] d,
                           input logic [7:0] r, input logic en);
        cmd_target = t; cmd_step = s; cmd_div = d; cmd_range = r; cmd_en = en;
    endtask

    task automatic send_cmd(input logic [7:0] t, input logic [7:0] s, input logic [3:0] d,
                            input logic [7:0] r, input logic en);
        @(negedge clk);
        set_cmd(t, s, d, r, en);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_ready", 32'(cmd_ready), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_value"}, 32'(pwm_value), 32'h00);
        check({tag, "_range"}, 32'(pwm_range), 32'hFF);
        check({tag, "_en"},    32'(pwm_en),    32'd0);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
    endtask

    initial begin
        int d0;
        int wait_cyc;
        reset = 1'b0; cmd_valid = 1'b0; cmd_abort = 1'b0; pwm_period = 1'b0;
        set_cmd(8'd0, 8'd0, 4'd0, 8'd0, 1'b0);

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1 check_reset_state("rst");
        @(negedge clk);
        reset = 1'b0;

        // Ramp up 0 -> 10 by 3.
        d0 = done_cnt;
        send_cmd(8'd10, 8'd3, 4'd0, 8'd100, 1'b1);
        check("pre_period_range", 32'(pwm_range), 32'hFF);
        pulse(mk(8'd3,  8'd100, 1'b1, 1'b0, 1'b1));
        pulse(mk(8'd6,  8'd100, 1'b1, 1'b0, 1'b1));
        pulse(mk(8'd9,  8'd100, 1'b1, 1'b0, 1'b1));
        pulse(mk(8'd10, 8'd100, 1'b1, 1'b1, 1'b0));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("ramp_up_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Divided ramp down 10 -> 0 by 5, step every third period.
        send_cmd(8'd0, 8'd5, 4'd2, 8'd50, 1'b0);
        pulse(mk(8'd10, 8'd50, 1'b0, 1'b0, 1'b1));
        pulse(mk(8'd10, 8'd50, 1'b0, 1'b0, 1'b1));
        pulse(mk(8'd5,  8'd50, 1'b0, 1'b0, 1'b1));
        pulse(mk(8'd5,  8'd50, 1'b0, 1'b0, 1'b1));
        pulse(mk(8'd5,  8'd50, 1'b0, 1'b0, 1'b1));
        pulse(mk(8'd0,  8'd50, 1'b0, 1'b1, 1'b0));

        // Jump with step 0, then a last step that must clamp instead of wrapping.
        send_cmd(8'd200, 8'd0, 4'd0, 8'd255, 1'b1);
        pulse(mk(8'd200, 8'd255, 1'b1, 1'b1, 1'b0));
        send_cmd(8'd250, 8'd0, 4'd0, 8'd255, 1'b1);
        pulse(mk(8'd250, 8'd255, 1'b1, 1'b1, 1'b0));
        send_cmd(8'd255, 8'd10, 4'd0, 8'd255, 1'b1);
        pulse(mk(8'd255, 8'd255, 1'b1, 1'b1, 1'b0));

        // Period pulse coincident with accept is ignored.
        @(negedge clk);
        set_cmd(8'd100, 8'd10, 4'd0, 8'd200, 1'b1);
        cmd_valid = 1'b1; pwm_period = 1'b1;
        sb_q.push_back(mk(8'd255, 8'd255, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        cmd_valid = 1'b0; pwm_period = 1'b0;
        pulse(mk(8'd245, 8'd200, 1'b1, 1'b0, 1'b1));
        pulse(mk(8'd235, 8'd200, 1'b1, 1'b0, 1'b1));

        // Abort together with a period pulse: value frozen, no done.
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        cmd_abort = 1'b1; pwm_period = 1'b1;
        sb_q.push_back(mk(8'd235, 8'd200, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        cmd_abort = 1'b0; pwm_period = 1'b0;
        check("abort_ready", 32'(cmd_ready), 32'd1);
        pulse(mk(8'd235, 8'd200, 1'b1, 1'b0, 1'b0));

        // Abort before the first period: range/en stay untouched.
        send_cmd(8'd0, 8'd1, 4'd0, 8'd10, 1'b0);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        check("abort_first_ready", 32'(cmd_ready), 32'd1);
        pulse(mk(8'd235, 8'd200, 1'b1, 1'b0, 1'b0));
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // cmd_valid held through RAMP is taken in the done cycle.
        send_cmd(8'd240, 8'd5, 4'd0, 8'd200, 1'b1);
        set_cmd(8'd0, 8'd0, 4'd0, 8'd128, 1'b0);
        cmd_valid = 1'b1;
        @(negedge clk);
        check("held_valid_ready", 32'(cmd_ready), 32'd0);
        pulse(mk(8'd240, 8'd200, 1'b1, 1'b1, 1'b0));
        check("b2b_ready_in_done", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        pulse(mk(8'd0, 8'd128, 1'b0, 1'b1, 1'b0));

        // Reset mid-fade, then a clean fade from 0.
        send_cmd(8'd100, 8'd10, 4'd0, 8'd90, 1'b1);
        pulse(mk(8'd10, 8'd90, 1'b1, 1'b0, 1'b1));
        #2 reset = 1'b1;
        #1 check_reset_state("midrst");
        @(negedge clk);
        reset = 1'b0;
        send_cmd(8'd20, 8'd20, 4'd0, 8'd60, 1'b1);
        pulse(mk(8'd20, 8'd60, 1'b1, 1'b1, 1'b0));

        wait_cyc = 0;
        while (sb_q.size() != 0 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Command-driven fade sequencer that sits directly upstream of the PWM core and drives its `pwm_value`, `pwm_range` and `pwm_en` inputs. It accepts a fade command over a valid/ready handshake and then steps `pwm_value` toward a target by a programmable step size. All output changes are synchronised to the core's `pwm_period` pulse, so duty and range never change mid-period. A completion pulse and a busy flag are returned to the command source.

## Interface
- `DATA_W`, default 8: width of value, range, target and step.
- `DIV_W`, default 4: width of the period divider (periods per step minus 1).
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command. Equals 1 exactly when the FSM is in IDLE.
- `cmd_target` in DATA_W: final `pwm_value`.
- `cmd_step` in DATA_W: increment per step; 0 means jump directly to target.
- `cmd_div` in DIV_W: a step is taken every `cmd_div+1` periods.
- `cmd_range` in DATA_W: `pwm_range` to apply.
- `cmd_en` in 1: `pwm_en` to apply.
- `cmd_abort` in 1: stop the fade in progress.
- `pwm_period` in 1: one-clk pulse from the PWM core at the end of each period.
- `pwm_value` out DATA_W: registered duty to the core.
- `pwm_range` out DATA_W: registered period range to the core.
- `pwm_en` out 1: registered enable to the core.
- `busy` out 1: FSM in RAMP.
- `done` out 1: one-clk completion pulse.

## Operation
- **FSM states:** IDLE and RAMP.
- **Reset values:** `pwm_value`=0, `pwm_range`={DATA_W{1}}, `pwm_en`=0, `done`=0, state IDLE (so `cmd_ready`=1, `busy`=0).
- **IDLE:**
  - Accept on `cmd_valid && cmd_ready`.
  - Latch target, step, div, range and en into shadow registers.
  - Load `div_cnt` <= `cmd_div` and set `first` <= 1.
  - Go to RAMP.
  - `pwm_period` in IDLE, including the accept cycle, is ignored.
- **RAMP:** act only on cycles with `pwm_period`=1.
  - If `first`: `pwm_range`/`pwm_en` <= shadow values; `first` <= 0. This period also counts as a divider tick.
  - If `div_cnt`!=0: decrement `div_cnt`.
  - Else reload `div_cnt` <= div and take a step:
    - diff = |target − `pwm_value`|, computed at DATA_W+1 bits, unsigned.
    - If step==0 or diff<=step: `pwm_value` <= target; go to IDLE; `done` <= 1.
    - Otherwise `pwm_value` <= `pwm_value` ± step, toward target.
  - Arithmetic never wraps: the final step always lands exactly on target.
- **Target equal to current value:** the first step tick finishes immediately, after range/en have been applied.
- **Target not clipped to range:** target is not clipped to `pwm_range`; the PWM core owns that interpretation.
- **`cmd_abort` in RAMP:**
  - Next edge goes to IDLE.
  - `pwm_value` is held at its current value; no `done` pulse.
  - If `first` was still set, range/en are not applied.
  - `cmd_abort` in IDLE has no effect.
- **Abort and period in the same cycle:** abort wins and no update occurs.
- **Commands during RAMP:** not accepted (`cmd_ready`=0); `cmd_valid` may stay high and is accepted once IDLE is reached.
- **`reset` asserted mid-fade:** all outputs return to their reset values immediately, without waiting for a clock edge.

## Timing
- **Output updates:** all outputs are registered. An update triggered by `pwm_period` at edge N is visible after edge N.
- **`done`:** high for exactly the one cycle after the final update edge, coincident with `pwm_value`==target; `cmd_ready` is 1 in that same cycle.
- **Back-to-back accept:** a new command may be accepted in the `done` cycle.
- **Latency:** accept to first range/en update is the first `pwm_period` after the accept cycle.
- **Step count:** a fade needs ceil(diff/step) steps; it completes on period number `(cmd_div+1)`·ceil(diff/step) after accept, or `cmd_div+1` if diff=0 or step=0.
- **No combinational paths:** no input drives an output combinationally except `cmd_ready`/`busy`, which are decoded from the state register only.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → outputs are 0/0xFF/0, `cmd_ready`=1, `busy`=0, `done`=0, without any clock edge.
- **Ramp up:** value 0, cmd target=10 step=3 div=0 range=100 en=1, periods every 16 clk → `pwm_range`=100 and `pwm_en`=1 at period 1. `pwm_value` takes 3, 6, 9, 10 on periods 1–4; `done` pulses once with 10.
- **Divided ramp down:** from 10, cmd target=0 step=5 div=2 → range/en change at period 1, `pwm_value` 5 at period 3 and 0 at period 6; `busy` drops with `done`.
- **Jump, no wrap:** step=0 target=200 → `pwm_value`=200 at period 1, `done`. Then from 250, target=255 step=10 → 255 in one step, never wraps to 4.
- **Abort and handshake:** `cmd_abort` in the same cycle as `pwm_period` mid-ramp → value frozen, no `done`, `cmd_ready`=1 next cycle. `cmd_valid` held through a RAMP → accepted only in the `done` cycle. `pwm_period` in the accept cycle → ignored.
- **Reset mid-fade:** `reset` pulsed during RAMP → immediate return to reset values; the next command starts cleanly from value 0.
